// File: rtl/axi_burst_arbiter_if.sv
// Command/completion bundle between two burst requesters, the arbiter and the AXI master datapath.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface axi_burst_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic                      req0_write;
    logic [AXI_ADDR_WIDTH-1:0] req0_addr;
    logic [7:0]                req0_len;
    logic [1:0]                req0_burst;
    logic                      req1_valid;
    logic                      req1_ready;
    logic                      req1_write;
    logic [AXI_ADDR_WIDTH-1:0] req1_addr;
    logic [7:0]                req1_len;
    logic [1:0]                req1_burst;
    logic                      done0;
    logic                      err0;
    logic                      done1;
    logic                      err1;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                cmd_len;
    logic [1:0]                cmd_burst;
    logic                      rd_done;
    logic                      wr_done;
    logic [1:0]                resp;
    logic                      grant_id;
    logic                      busy;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_len, req0_burst,
        input  req1_valid, req1_write, req1_addr, req1_len, req1_burst,
        input  cmd_ready, rd_done, wr_done, resp,
        output req0_ready, req1_ready, done0, err0, done1, err1,
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst,
        output grant_id, busy
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_len, req0_burst,
        output req1_valid, req1_write, req1_addr, req1_len, req1_burst,
        output cmd_ready, rd_done, wr_done, resp,
        input  req0_ready, req1_ready, done0, err0, done1, err1,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst,
        input  grant_id, busy
    );
endinterface

// File: rtl/axi_burst_arbiter.sv
// Two-requester round-robin arbiter keeping a single AXI burst outstanding,
// with per-burst completion/error reporting and a WAIT_DONE timeout.
module axi_burst_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input logic               aclk,
    input logic               aresetn,
    axi_burst_arbiter_if.master bus
);
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_req0_ready;
    logic                      r_req1_ready;
    logic                      r_grant;
    logic                      r_last;
    logic                      r_last_vld;
    logic                      r_err;
    logic [15:0]               r_cnt;
    logic                      r_cmd_write;
    logic [AXI_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [7:0]                r_cmd_len;
    logic [1:0]                r_cmd_burst;

    logic                      w_any;
    logic                      w_win;
    logic                      w_cmplt;
    logic                      w_tmo;
    logic [15:0]               w_cnt_nxt;

    assign w_any = bus.req0_valid | bus.req1_valid;

    // With no completed burst since reset, requester 0 wins a tie.
    always_comb begin
        w_win = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            w_win = r_last_vld ? ~r_last : 1'b0;
    end

    assign w_cmplt   = r_cmd_write ? bus.wr_done : bus.rd_done;
    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_tmo     = (w_cnt_nxt == TMO);

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_any)                w_state_nxt = ISSUE;
            ISSUE:     if (bus.cmd_ready)        w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (w_cmplt || w_tmo)     w_state_nxt = RESP;
            RESP:                                w_state_nxt = IDLE;
            default:                             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_grant      <= 1'b0;
            r_last       <= 1'b0;
            r_last_vld   <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= 16'd0;
            r_cmd_write  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= 8'd0;
            r_cmd_burst  <= 2'd0;
        end else begin
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req0_ready <= ~w_win;
                        r_req1_ready <= w_win;
                        r_grant      <= w_win;
                        r_err        <= 1'b0;
                        r_cmd_write  <= w_win ? bus.req1_write : bus.req0_write;
                        r_cmd_addr   <= w_win ? bus.req1_addr  : bus.req0_addr;
                        r_cmd_len    <= w_win ? bus.req1_len   : bus.req0_len;
                        r_cmd_burst  <= w_win ? bus.req1_burst : bus.req0_burst;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) r_cnt <= 16'd0;
                end
                WAIT_DONE: begin
                    // Completion beats a timeout landing on the same cycle.
                    if (w_cmplt)    r_err <= (bus.resp != 2'b00);
                    else if (w_tmo) r_err <= 1'b1;
                    else            r_cnt <= w_cnt_nxt;
                end
                RESP: begin
                    r_last     <= r_grant;
                    r_last_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = r_req0_ready;
    assign bus.req1_ready = r_req1_ready;
    assign bus.cmd_valid  = (r_state == ISSUE);
    assign bus.cmd_write  = r_cmd_write;
    assign bus.cmd_addr   = r_cmd_addr;
    assign bus.cmd_len    = r_cmd_len;
    assign bus.cmd_burst  = r_cmd_burst;
    assign bus.grant_id   = r_grant;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done0      = (r_state == RESP) & ~r_grant;
    assign bus.done1      = (r_state == RESP) &  r_grant;
    assign bus.err0       = bus.done0 & r_err;
    assign bus.err1       = bus.done1 & r_err;
endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Directed bench for axi_burst_arbiter: expected commands and completions are queued as
// stimulus is driven and popped by a negedge monitor when the DUT produces them.
module tb_axi_burst_arbiter;
    localparam int AW  = 32;
    localparam int TMO = 8;

    typedef struct packed {
        logic          id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [1:0]    burst;
    } cmd_t;

    typedef struct packed {
        logic [1:0] done;   // {done1, done0}
        logic [1:0] err;    // {err1, err0}
    } done_t;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_chk  = 0;
    int   n_pass = 0;
    cmd_t  exp_cmd[$];
    done_t exp_done[$];

    axi_burst_arbiter_if #(.AXI_ADDR_WIDTH(AW)) bus ();

    axi_burst_arbiter #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drive_req(input cmd_t c);
        if (c.id) begin
            bus.req1_valid = 1'b1; bus.req1_write = c.wr; bus.req1_addr = c.addr;
            bus.req1_len   = c.len; bus.req1_burst = c.burst;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_write = c.wr; bus.req0_addr = c.addr;
            bus.req0_len   = c.len; bus.req0_burst = c.burst;
        end
    endtask

    // cyc counts negedges up to and including the one where a done pulse is seen.
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            @(negedge aclk);
            cyc++;
            if (bus.done0 || bus.done1) return;
        end
        n_chk++;
        $error("FAIL done_wait: no done pulse within %0d cycles", max);
    endtask

    always @(negedge aclk) begin
        cmd_t  e_c;
        done_t e_d;
        if (bus.cmd_valid && bus.cmd_ready) begin
            if (exp_cmd.size() == 0) chk("cmd_unexpected", bus.cmd_valid & bus.cmd_ready, 0);
            else begin
                e_c = exp_cmd.pop_front();
                chk("cmd", {bus.grant_id, bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.cmd_burst}, e_c);
            end
        end
        if (bus.done0 || bus.done1) begin
            if (exp_done.size() == 0) chk("done_unexpected", {bus.done1, bus.done0}, 2'b00);
            else begin
                e_d = exp_done.pop_front();
                chk("done", {bus.done1, bus.done0, bus.err1, bus.err0}, e_d);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_t  c0, c1;
        cmd_t  seq[4];
        done_t dseq[4];
        int    cyc;

        aresetn = 1'b0;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_len = 0; bus.req0_burst = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_len = 0; bus.req1_burst = 0;
        bus.cmd_ready = 0; bus.rd_done = 0; bus.wr_done = 0; bus.resp = 0;

        // Reset state
        tick(3);
        @(negedge aclk);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_ready",     {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_done_err",  {bus.done1, bus.done0, bus.err1, bus.err0}, 0);
        chk("rst_grant",     bus.grant_id, 0);
        chk("rst_cmd",       {bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.cmd_burst}, 0);

        // Single read from requester 0, granted on the first edge out of reset
        tick(1);
        aresetn = 1'b1;
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h4000_0000, len: 8'd3, burst: 2'd1};
        exp_cmd.push_back(c0);
        drive_req(c0);
        bus.cmd_ready = 1'b1;
        tick(1);
        @(negedge aclk);
        chk("s1_ready",     {bus.req1_ready, bus.req0_ready}, 2'b01);
        chk("s1_busy",      bus.busy, 1);
        chk("s1_cmd_valid", bus.cmd_valid, 1);
        tick(1);
        bus.req0_valid = 1'b0;
        @(negedge aclk);
        chk("s1_ready_pulse", {bus.req1_ready, bus.req0_ready}, 2'b00);
        chk("s1_wait_valid",  bus.cmd_valid, 0);
        tick(3);
        bus.rd_done = 1'b1; bus.resp = 2'b00;
        exp_done.push_back('{done: 2'b01, err: 2'b00});
        tick(1);
        bus.rd_done = 1'b0;
        wait_done(8, cyc);
        tick(1);
        @(negedge aclk);
        chk("s1_idle_busy",  bus.busy, 0);
        chk("s1_done_pulse", {bus.done1, bus.done0}, 2'b00);

        // Both requesters held valid, completing at once; last grant was 0 so 1 leads
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h0000_1000, len: 8'd1, burst: 2'd1};
        c1 = '{id: 1'b1, wr: 1'b0, addr: 32'h0000_2000, len: 8'd2, burst: 2'd1};
        seq[0] = c1; seq[1] = c0; seq[2] = c1; seq[3] = c0;
        dseq[0] = '{2'b10, 2'b00}; dseq[1] = '{2'b01, 2'b00};
        dseq[2] = '{2'b10, 2'b00}; dseq[3] = '{2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back(seq[i]);
            exp_done.push_back(dseq[i]);
        end
        tick(1);
        drive_req(c0); drive_req(c1);
        bus.rd_done = 1'b1; bus.resp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            wait_done(16, cyc);
            if (i > 0) chk("s2_spacing", cyc, 4);
        end
        tick(1);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rd_done = 1'b0;

        // Requester 1 write with SLVERR; read completions during it must be ignored
        tick(2);
        c1 = '{id: 1'b1, wr: 1'b1, addr: 32'h8000_1000, len: 8'd15, burst: 2'd1};
        exp_cmd.push_back(c1);
        exp_done.push_back('{done: 2'b10, err: 2'b10});
        drive_req(c1);
        tick(1);
        bus.req1_valid = 1'b0;
        tick(1);
        bus.rd_done = 1'b1; bus.resp = 2'b11;
        tick(2);
        bus.rd_done = 1'b0;
        @(negedge aclk);
        chk("s3_rd_ignored_busy", bus.busy, 1);
        chk("s3_rd_ignored_done", {bus.done1, bus.done0}, 2'b00);
        tick(1);
        bus.wr_done = 1'b1; bus.resp = 2'b10;
        tick(1);
        bus.wr_done = 1'b0; bus.resp = 2'b00;
        wait_done(8, cyc);

        // Timeout: no completion; wait starts inside the entry cycle, so TMO edges later is TMO+1 negedges
        tick(2);
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h4000_0100, len: 8'd0, burst: 2'd1};
        exp_cmd.push_back(c0);
        exp_done.push_back('{done: 2'b01, err: 2'b01});
        drive_req(c0);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(1);
        wait_done(20, cyc);
        chk("s4_timeout_cycles", cyc, TMO + 1);
        tick(1);
        @(negedge aclk);
        chk("s4_idle_busy", bus.busy, 0);

        // Completion in the very cycle the timeout would fire: completion wins
        tick(2);
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h4000_0200, len: 8'd7, burst: 2'd2};
        exp_cmd.push_back(c0);
        exp_done.push_back('{done: 2'b01, err: 2'b00});
        drive_req(c0);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(1);
        tick(TMO - 1);
        bus.rd_done = 1'b1; bus.resp = 2'b00;
        tick(1);
        bus.rd_done = 1'b0;
        wait_done(4, cyc);
        chk("s4b_latency", cyc, 1);

        // ISSUE stall: command held stable and timeout counter idle until accepted
        tick(2);
        bus.cmd_ready = 1'b0;
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h1234_5678, len: 8'd7, burst: 2'd2};
        exp_cmd.push_back(c0);
        exp_done.push_back('{done: 2'b01, err: 2'b01});
        drive_req(c0);
        tick(1);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.req0_addr = $urandom();
            bus.req0_len  = 8'($urandom_range(0, 255));
            @(negedge aclk);
            chk("s5_stall", {bus.cmd_valid, bus.grant_id, bus.cmd_write, bus.cmd_addr,
                             bus.cmd_len, bus.cmd_burst}, {1'b1, c0});
            tick(1);
        end
        bus.cmd_ready = 1'b1;
        tick(1);
        wait_done(20, cyc);
        chk("s5_timeout_cycles", cyc, TMO + 1);

        // Reset during WAIT_DONE aborts silently and restores requester 0 priority
        tick(2);
        c1 = '{id: 1'b1, wr: 1'b0, addr: 32'h0000_0040, len: 8'd0, burst: 2'd1};
        exp_cmd.push_back(c1);
        drive_req(c1);
        tick(1);
        bus.req1_valid = 1'b0;
        tick(3);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("s6_busy",      bus.busy, 0);
        chk("s6_cmd_valid", bus.cmd_valid, 0);
        chk("s6_grant",     bus.grant_id, 0);
        tick(1);
        c0 = '{id: 1'b0, wr: 1'b0, addr: 32'h0000_0080, len: 8'd1, burst: 2'd1};
        c1 = '{id: 1'b1, wr: 1'b0, addr: 32'h0000_00C0, len: 8'd1, burst: 2'd1};
        exp_cmd.push_back(c0);
        exp_done.push_back('{done: 2'b01, err: 2'b00});
        drive_req(c0); drive_req(c1);
        tick(1);
        @(negedge aclk);
        chk("s6_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        tick(1);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rd_done = 1'b1; bus.resp = 2'b00;
        tick(1);
        bus.rd_done = 1'b0;
        wait_done(8, cyc);

        tick(3);
        chk("sb_cmd_empty",  exp_cmd.size(), 0);
        chk("sb_done_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
